// File: rtl/chacha20_poly1305_framer.sv
// chacha20_poly1305_framer
//   Upstream framing stage for chacha20_poly1305_core. Takes one AEAD message
//   as an AAD byte stream followed by a payload byte stream (128-bit beats with
//   byte keep and last), forwards beats to the core's aad/pld block ports
//   through single-entry output registers, counts bytes per segment and then
//   presents the le64(aad_len) || le64(ct_len) length block on the len port.
//
// Ports
//   i_clk, i_rst_n              clock, async active-low reset
//   i_start                     begins a message (IDLE only)
//   i_s_aad_* / o_s_aad_ready   AAD input stream (valid, data, keep, last)
//   i_s_pld_* / o_s_pld_ready   payload input stream
//   o_m_aad_* / i_m_aad_ready   to core aad_* (valid, data, keep)
//   o_m_pld_* / i_m_pld_ready   to core pld_*
//   o_m_len_valid/_block, i_m_len_ready  to core len_*
//   o_aad_bytes, o_pld_bytes    running byte counts for the current message
//   o_busy, o_done, o_err       status: not idle, length accepted, sticky error
//
// state | meaning
// IDLE  | waiting for start; counters and length block hold last message
// AAD   | accepting / forwarding AAD beats
// PLD   | accepting / forwarding payload beats
// LEN   | presenting the length block to the core

module chacha20_poly1305_framer #(
  parameter int CNT_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_s_aad_valid,
  output logic             o_s_aad_ready,
  input  logic [127:0]     i_s_aad_data,
  input  logic [15:0]      i_s_aad_keep,
  input  logic             i_s_aad_last,
  input  logic             i_s_pld_valid,
  output logic             o_s_pld_ready,
  input  logic [127:0]     i_s_pld_data,
  input  logic [15:0]      i_s_pld_keep,
  input  logic             i_s_pld_last,
  output logic             o_m_aad_valid,
  input  logic             i_m_aad_ready,
  output logic [127:0]     o_m_aad_data,
  output logic [15:0]      o_m_aad_keep,
  output logic             o_m_pld_valid,
  input  logic             i_m_pld_ready,
  output logic [127:0]     o_m_pld_data,
  output logic [15:0]      o_m_pld_keep,
  output logic             o_m_len_valid,
  input  logic             i_m_len_ready,
  output logic [127:0]     o_m_len_block,
  output logic [CNT_W-1:0] o_aad_bytes,
  output logic [CNT_W-1:0] o_pld_bytes,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AAD  = 2'd1,
    S_PLD  = 2'd2,
    S_LEN  = 2'd3
  } state_t;

  state_t r_state, r_state_nxt;

  logic             r_m_aad_valid, r_m_pld_valid;
  logic [127:0]     r_m_aad_data, r_m_pld_data;
  logic [15:0]      r_m_aad_keep, r_m_pld_keep;
  logic             r_aad_last_fwd, r_pld_last_fwd;  // registered beat is the segment's last
  logic             r_aad_last_acc, r_pld_last_acc;  // last beat of segment already taken
  logic [CNT_W-1:0] r_aad_bytes, r_pld_bytes;
  logic             r_done, r_err;

  logic       w_start;
  logic       w_aad_acc, w_pld_acc;
  logic       w_aad_drain, w_pld_drain;
  logic       w_aad_empty, w_pld_empty;
  logic       w_aad_end, w_pld_end;
  logic       w_aad_bad, w_pld_bad;
  logic [4:0] w_aad_pcnt, w_pld_pcnt;
  logic       w_len_hs;

  function automatic logic [4:0] f_popcnt(input logic [15:0] keep);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'd0, keep[i]};
    return cnt;
  endfunction

  // keep is contiguous from bit 0 exactly when keep+1 shares no bits with keep.
  // A zero keep is only legal as the empty last beat; any partial keep must be last.
  function automatic logic f_keep_bad(input logic [15:0] keep, input logic last);
    logic contig;
    contig = ((keep + 16'd1) & keep) == 16'd0;
    if (keep == 16'd0) return !last;
    return !contig || (!last && (keep != 16'hFFFF));
  endfunction

  assign w_start     = (r_state == S_IDLE) && i_start;

  assign w_aad_acc   = i_s_aad_valid && o_s_aad_ready;
  assign w_pld_acc   = i_s_pld_valid && o_s_pld_ready;
  assign w_aad_drain = r_m_aad_valid && i_m_aad_ready;
  assign w_pld_drain = r_m_pld_valid && i_m_pld_ready;
  assign w_aad_empty = w_aad_acc && (i_s_aad_keep == 16'd0);
  assign w_pld_empty = w_pld_acc && (i_s_pld_keep == 16'd0);
  assign w_aad_end   = (w_aad_drain && r_aad_last_fwd) || (w_aad_empty && i_s_aad_last);
  assign w_pld_end   = (w_pld_drain && r_pld_last_fwd) || (w_pld_empty && i_s_pld_last);
  assign w_aad_bad   = f_keep_bad(i_s_aad_keep, i_s_aad_last);
  assign w_pld_bad   = f_keep_bad(i_s_pld_keep, i_s_pld_last);
  assign w_aad_pcnt  = f_popcnt(i_s_aad_keep);
  assign w_pld_pcnt  = f_popcnt(i_s_pld_keep);
  assign w_len_hs    = o_m_len_valid && i_m_len_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start)   r_state_nxt = S_AAD;
      S_AAD:   if (w_aad_end) r_state_nxt = S_PLD;
      S_PLD:   if (w_pld_end) r_state_nxt = S_LEN;
      S_LEN:   if (w_len_hs)  r_state_nxt = S_IDLE;
      default:                r_state_nxt = S_IDLE;
    endcase
  end

  // AAD output register: load on accept of a non-empty beat, otherwise drain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m_aad_valid  <= 1'b0;
      r_m_aad_data   <= '0;
      r_m_aad_keep   <= '0;
      r_aad_last_fwd <= 1'b0;
      r_aad_last_acc <= 1'b0;
    end else begin
      if (w_aad_acc && !w_aad_empty) begin
        r_m_aad_valid  <= 1'b1;
        r_m_aad_data   <= i_s_aad_data;
        r_m_aad_keep   <= i_s_aad_keep;
        r_aad_last_fwd <= i_s_aad_last;
      end else if (w_aad_drain) begin
        r_m_aad_valid  <= 1'b0;
      end
      if (w_start)                        r_aad_last_acc <= 1'b0;
      else if (w_aad_acc && i_s_aad_last) r_aad_last_acc <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m_pld_valid  <= 1'b0;
      r_m_pld_data   <= '0;
      r_m_pld_keep   <= '0;
      r_pld_last_fwd <= 1'b0;
      r_pld_last_acc <= 1'b0;
    end else begin
      if (w_pld_acc && !w_pld_empty) begin
        r_m_pld_valid  <= 1'b1;
        r_m_pld_data   <= i_s_pld_data;
        r_m_pld_keep   <= i_s_pld_keep;
        r_pld_last_fwd <= i_s_pld_last;
      end else if (w_pld_drain) begin
        r_m_pld_valid  <= 1'b0;
      end
      if (w_start)                        r_pld_last_acc <= 1'b0;
      else if (w_pld_acc && i_s_pld_last) r_pld_last_acc <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aad_bytes <= '0;
      r_pld_bytes <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_len_hs;
      if (w_start) begin
        r_aad_bytes <= '0;
        r_pld_bytes <= '0;
        r_err       <= 1'b0;
      end else begin
        if (w_aad_acc) r_aad_bytes <= r_aad_bytes + CNT_W'(w_aad_pcnt);
        if (w_pld_acc) r_pld_bytes <= r_pld_bytes + CNT_W'(w_pld_pcnt);
        if ((w_aad_acc && w_aad_bad) || (w_pld_acc && w_pld_bad)) r_err <= 1'b1;
      end
    end
  end

  assign o_s_aad_ready = (r_state == S_AAD) && (!r_m_aad_valid || i_m_aad_ready) && !r_aad_last_acc;
  assign o_s_pld_ready = (r_state == S_PLD) && (!r_m_pld_valid || i_m_pld_ready) && !r_pld_last_acc;

  assign o_m_aad_valid = r_m_aad_valid;
  assign o_m_aad_data  = r_m_aad_data;
  assign o_m_aad_keep  = r_m_aad_keep;
  assign o_m_pld_valid = r_m_pld_valid;
  assign o_m_pld_data  = r_m_pld_data;
  assign o_m_pld_keep  = r_m_pld_keep;

  // Counters are frozen outside AAD/PLD, so the block is stable in LEN and IDLE.
  assign o_m_len_valid = (r_state == S_LEN);
  assign o_m_len_block = {64'(r_pld_bytes), 64'(r_aad_bytes)};

  assign o_aad_bytes   = r_aad_bytes;
  assign o_pld_bytes   = r_pld_bytes;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_chacha20_poly1305_framer.sv
`timescale 1ns/1ps
module tb_chacha20_poly1305_framer;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_s_aad_valid = 1'b0, i_s_aad_last = 1'b0;
  logic [127:0] i_s_aad_data = '0;
  logic [15:0]  i_s_aad_keep = '0;
  logic         i_s_pld_valid = 1'b0, i_s_pld_last = 1'b0;
  logic [127:0] i_s_pld_data = '0;
  logic [15:0]  i_s_pld_keep = '0;
  logic         i_m_aad_ready = 1'b1, i_m_pld_ready = 1'b1, i_m_len_ready = 1'b1;
  logic         o_s_aad_ready, o_s_pld_ready;
  logic         o_m_aad_valid, o_m_pld_valid, o_m_len_valid;
  logic [127:0] o_m_aad_data, o_m_pld_data, o_m_len_block;
  logic [15:0]  o_m_aad_keep, o_m_pld_keep;
  logic [63:0]  o_aad_bytes, o_pld_bytes;
  logic         o_busy, o_done, o_err;

  chacha20_poly1305_framer #(.CNT_W(64)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_s_aad_valid(i_s_aad_valid), .o_s_aad_ready(o_s_aad_ready),
    .i_s_aad_data(i_s_aad_data), .i_s_aad_keep(i_s_aad_keep), .i_s_aad_last(i_s_aad_last),
    .i_s_pld_valid(i_s_pld_valid), .o_s_pld_ready(o_s_pld_ready),
    .i_s_pld_data(i_s_pld_data), .i_s_pld_keep(i_s_pld_keep), .i_s_pld_last(i_s_pld_last),
    .o_m_aad_valid(o_m_aad_valid), .i_m_aad_ready(i_m_aad_ready),
    .o_m_aad_data(o_m_aad_data), .o_m_aad_keep(o_m_aad_keep),
    .o_m_pld_valid(o_m_pld_valid), .i_m_pld_ready(i_m_pld_ready),
    .o_m_pld_data(o_m_pld_data), .o_m_pld_keep(o_m_pld_keep),
    .o_m_len_valid(o_m_len_valid), .i_m_len_ready(i_m_len_ready),
    .o_m_len_block(o_m_len_block),
    .o_aad_bytes(o_aad_bytes), .o_pld_bytes(o_pld_bytes),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Monitor: forwarded beats, done pulses, hold-stability and ordering violations.
  logic [127:0] aad_q[$], pld_q[$];
  logic [15:0]  pld_keep_q[$];
  int           n_done = 0;
  int           n_unstable = 0;
  int           n_order = 0;
  int           exp_aad = 0;
  logic         hold_aad_v = 1'b0, hold_pld_v = 1'b0;
  logic [127:0] hold_aad = '0, hold_pld = '0;

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      hold_aad_v = 1'b0;
      hold_pld_v = 1'b0;
    end else begin
      if (hold_aad_v && (!o_m_aad_valid || o_m_aad_data !== hold_aad)) n_unstable++;
      if (hold_pld_v && (!o_m_pld_valid || o_m_pld_data !== hold_pld)) n_unstable++;
      hold_aad_v = o_m_aad_valid && !i_m_aad_ready;
      hold_aad   = o_m_aad_data;
      hold_pld_v = o_m_pld_valid && !i_m_pld_ready;
      hold_pld   = o_m_pld_data;
      if (o_m_aad_valid && i_m_aad_ready) aad_q.push_back(o_m_aad_data);
      if (o_m_pld_valid && i_m_pld_ready) begin
        pld_q.push_back(o_m_pld_data);
        pld_keep_q.push_back(o_m_pld_keep);
      end
      if (o_done) n_done++;
      if (o_s_pld_ready && aad_q.size() < exp_aad) n_order++;
      if (o_m_len_valid && o_m_pld_valid) n_order++;
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic do_start();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send(input bit pld, input logic [127:0] d, input logic [15:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    if (pld) begin
      i_s_pld_valid = 1'b1; i_s_pld_data = d; i_s_pld_keep = k; i_s_pld_last = l;
    end else begin
      i_s_aad_valid = 1'b1; i_s_aad_data = d; i_s_aad_keep = k; i_s_aad_last = l;
    end
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge i_clk);
      if (pld ? o_s_pld_ready : o_s_aad_ready) begin
        @(posedge i_clk); #1;
        ok = 1'b1;
      end
    end
    i_s_aad_valid = 1'b0;
    i_s_pld_valid = 1'b0;
    if (!ok) check(pld ? "pld_accept_timeout" : "aad_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge i_clk);
      if (!o_busy) begin
        check("done_with_idle", o_done, 1);
        ok = 1'b1;
      end
    end
    if (!ok) check("idle_timeout", 0, 1);
    @(posedge i_clk); #1;
  endtask

  task automatic clear_mon(input int naad);
    aad_q.delete(); pld_q.delete(); pld_keep_q.delete();
    n_done = 0; n_unstable = 0; n_order = 0; exp_aad = naad;
  endtask

  localparam logic [127:0] A0 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] A1 = 128'h1f1e1d1c1b1a19181716151413121110;
  localparam logic [127:0] A2 = 128'h2f2e2d2c2b2a29282726252423222120;
  localparam logic [127:0] P0 = 128'hdeadbeef00112233445566778899aabb;
  localparam logic [127:0] P1 = 128'hcafef00d0102030405060708090a0b0c;
  localparam logic [127:0] P2 = 128'h00000000000000005555666677778888;

  initial begin
    // reset values
    #12;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_s_aad_ready", o_s_aad_ready, 0);
    check("rst_m_len_valid", o_m_len_valid, 0);
    check("rst_len_block", o_m_len_block, 0);
    check("rst_aad_bytes", o_aad_bytes, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // 1: 2 AAD beats, 3 payload beats, last keep 00FF
    clear_mon(2);
    do_start();
    check("t1_s_aad_ready_after_start", o_s_aad_ready, 1);
    check("t1_busy", o_busy, 1);
    send(0, A0, 16'hFFFF, 0);
    send(0, A1, 16'hFFFF, 1);
    send(1, P0, 16'hFFFF, 0);
    send(1, P1, 16'hFFFF, 0);
    send(1, P2, 16'h00FF, 1);
    wait_idle();
    check("t1_aad_bytes", o_aad_bytes, 32);
    check("t1_pld_bytes", o_pld_bytes, 40);
    check("t1_len_block", o_m_len_block, 128'h0000000000000028_0000000000000020);
    check("t1_err", o_err, 0);
    check("t1_done_count", n_done, 1);
    check("t1_aad_n", aad_q.size(), 2);
    check("t1_pld_n", pld_q.size(), 3);
    if (aad_q.size() == 2) begin
      check("t1_aad0", aad_q[0], A0);
      check("t1_aad1", aad_q[1], A1);
    end
    if (pld_q.size() == 3) begin
      check("t1_pld0", pld_q[0], P0);
      check("t1_pld1", pld_q[1], P1);
      check("t1_pld2", pld_q[2], P2);
      check("t1_pld2_keep", pld_keep_q[2], 16'h00FF);
    end
    check("t1_order", n_order, 0);

    // 2: empty AAD then one full payload beat
    clear_mon(0);
    do_start();
    send(0, A0, 16'h0000, 1);
    send(1, P1, 16'hFFFF, 1);
    wait_idle();
    check("t2_no_aad_fwd", aad_q.size(), 0);
    check("t2_aad_bytes", o_aad_bytes, 0);
    check("t2_len_block", o_m_len_block, 128'h0000000000000010_0000000000000000);
    check("t2_err", o_err, 0);

    // 3: toggling AAD ready, payload held off for 5 cycles
    clear_mon(3);
    i_m_pld_ready = 1'b0;
    do_start();
    fork
      begin
        send(0, A0, 16'hFFFF, 0);
        send(0, A1, 16'hFFFF, 0);
        send(0, A2, 16'hFFFF, 1);
      end
      begin
        for (int i = 0; i < 12; i++) begin
          i_m_aad_ready = (i % 2 == 0);
          @(posedge i_clk); #1;
        end
        i_m_aad_ready = 1'b1;
      end
    join
    send(1, P0, 16'hFFFF, 0);
    fork
      send(1, P1, 16'hFFFF, 1);
      begin
        repeat (3) @(posedge i_clk);
        #1 check("t3_pld_held", o_m_pld_data, P0);
        repeat (2) @(posedge i_clk);
        #1 i_m_pld_ready = 1'b1;
      end
    join
    wait_idle();
    check("t3_aad_n", aad_q.size(), 3);
    if (aad_q.size() == 3) begin
      check("t3_aad0", aad_q[0], A0);
      check("t3_aad1", aad_q[1], A1);
      check("t3_aad2", aad_q[2], A2);
    end
    check("t3_pld_n", pld_q.size(), 2);
    if (pld_q.size() == 2) begin
      check("t3_pld0", pld_q[0], P0);
      check("t3_pld1", pld_q[1], P1);
    end
    check("t3_unstable", n_unstable, 0);
    check("t3_order", n_order, 0);
    check("t3_aad_bytes", o_aad_bytes, 48);
    check("t3_pld_bytes", o_pld_bytes, 32);

    // 4: partial keep on non-last payload beat -> sticky err
    clear_mon(1);
    do_start();
    send(0, A0, 16'hFFFF, 1);
    send(1, P0, 16'h000F, 0);
    check("t4_err_set", o_err, 1);
    send(1, P1, 16'hFFFF, 1);
    wait_idle();
    check("t4_err_sticky", o_err, 1);
    check("t4_pld_bytes", o_pld_bytes, 20);
    check("t4_len_block", o_m_len_block, 128'h0000000000000014_0000000000000010);
    do_start();
    check("t4_err_cleared", o_err, 0);
    check("t4_cnt_cleared", o_aad_bytes, 0);

    // 5: reset while in PLD with m_pld_valid=1
    send(0, A0, 16'hFFFF, 1);
    i_m_pld_ready = 1'b0;
    send(1, P0, 16'hFFFF, 0);
    check("t5_pld_valid_pre", o_m_pld_valid, 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_pld_valid", o_m_pld_valid, 0);
    check("t5_rst_pld_data", o_m_pld_data, 0);
    check("t5_rst_s_pld_ready", o_s_pld_ready, 0);
    check("t5_rst_aad_bytes", o_aad_bytes, 0);
    check("t5_rst_len_block", o_m_len_block, 0);
    @(posedge i_clk); #3;
    i_rst_n = 1'b1;
    i_m_pld_ready = 1'b1;
    @(posedge i_clk); #1;
    clear_mon(1);
    do_start();
    send(0, A1, 16'h0007, 1);
    send(1, P2, 16'h003F, 1);
    wait_idle();
    check("t5_aad_bytes", o_aad_bytes, 3);
    check("t5_pld_bytes", o_pld_bytes, 6);
    check("t5_len_block", o_m_len_block, 128'h0000000000000006_0000000000000003);
    check("t5_err", o_err, 0);

    // 6: start during AAD is ignored
    clear_mon(2);
    do_start();
    send(0, A0, 16'hFFFF, 0);
    do_start();
    check("t6_busy", o_busy, 1);
    check("t6_aad_mid", o_aad_bytes, 16);
    send(0, A1, 16'hFFFF, 1);
    send(1, P0, 16'hFFFF, 1);
    wait_idle();
    check("t6_aad_bytes", o_aad_bytes, 32);
    check("t6_pld_bytes", o_pld_bytes, 16);
    check("t6_aad_n", aad_q.size(), 2);
    check("t6_done_count", n_done, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chacha20_poly1305_framer.md
# chacha20_poly1305_framer

Upstream framing stage for `chacha20_poly1305_core`. Accepts one AEAD message as two ordered byte streams, AAD then payload, in 128-bit beats with byte-keep and last flags. It forwards the beats to the core's `aad_*` and `pld_*` block interfaces, counts bytes per segment, and generates the RFC 8439 length block on the core's `len_*` interface. It enforces segment ordering so the core sees AAD, then payload, then length, once per message.

## Interface
Parameters
- `CNT_W`, default 64: byte-counter width, 64 per RFC 8439.

Ports
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a message. Honoured only in IDLE.
- `s_aad_valid` / `s_aad_ready`  in / out  1 / 1  AAD input handshake.
- `s_aad_data`  in  128  AAD beat. Byte 0 is in `[7:0]`.
- `s_aad_keep`  in  16  byte-valid mask. Must be contiguous from bit 0.
- `s_aad_last`  in  1  final beat of the AAD segment.
- `s_pld_valid`, `s_pld_ready`, `s_pld_data`, `s_pld_keep`, `s_pld_last`: same meanings, for the payload segment.
- `m_aad_valid` / `m_aad_ready`  out / in  1 / 1  drives core `aad_valid` / `aad_ready`.
- `m_aad_data`, `m_aad_keep`  out  128, 16  drive core `aad_data`, `aad_keep`.
- `m_pld_valid`, `m_pld_ready`, `m_pld_data`, `m_pld_keep`: same, to core `pld_*`.
- `m_len_valid` / `m_len_ready`  out / in  1 / 1  drives core `len_valid` / `len_ready`.
- `m_len_block`  out  128  drives core `len_block`.
- `aad_bytes`, `pld_bytes`  out  `CNT_W`  running byte counts for the current message.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the length block has been accepted.
- `err`  out  1  sticky protocol-error flag. Cleared by `start` or reset.

## Operation
- States: IDLE → AAD → PLD → LEN → IDLE.
- IDLE:
  - `start` clears both counters and `err`, then moves to AAD.
  - `start` in any other state is ignored.
- Output register, one per channel (`m_aad`, `m_pld`):
  - Each is a single-entry register.
  - `s_x_ready` = state is X, and (`!m_x_valid` or `m_x_ready`), and no last beat of X has yet been accepted.
  - An accepted beat is loaded into `m_x_*` on the same edge.
- Byte counting: on each accepted beat, `x_bytes += popcount(keep)`, modulo 2^`CNT_W`.
- Empty segment: a beat with `keep==0` and `last==1`:
  - is accepted and ends the segment;
  - adds 0 to the count;
  - is not forwarded; `m_x_valid` is not set.
- Other `keep==0` beats: consumed and not forwarded, with `err` set.
- Keep errors: a non-contiguous keep, or a partial keep (`keep!=16'hFFFF`) on a beat with `last==0`, sets `err`. The beat is still forwarded and counted by popcount.
- AAD → PLD: on the handshake (`m_aad_valid && m_aad_ready`) of the registered last AAD beat, or on acceptance of an empty AAD last beat.
- PLD → LEN: same rule, on the payload channel.
- LEN:
  - `m_len_block[63:0] = aad_bytes`, `m_len_block[127:64] = pld_bytes`. This is le64(aad) ‖ le64(ct) with byte 0 in `[7:0]`.
  - `m_len_valid` is held until `m_len_ready`.
  - The handshake pulses `done` and returns to IDLE.
- Segments are strictly ordered. Payload beats are never accepted while AAD is outstanding, and `m_len_valid` is never asserted while `m_pld_valid` is high.

## Timing
- Reset values:
  - state IDLE;
  - all `*_valid`, `*_ready`, `busy`, `done`, `err` = 0;
  - `m_*_data`, `m_*_keep`, `m_len_block`, `aad_bytes`, `pld_bytes` = 0.
- Beat latency is 1 cycle: a beat accepted at edge N appears on `m_x_*` after edge N.
- Full throughput: one beat per cycle when `m_x_ready` is held high.
- Simultaneous accept and drain in the same cycle reloads the register with no bubble.
- `s_aad_ready` is first high in the cycle after `start`.
- `s_pld_ready` is first high in the cycle after the final AAD drain.
- `m_len_valid` rises in the cycle after the final payload drain. `m_len_block` is stable while it is high.
- `done` is high for the cycle after the `m_len` handshake. `busy` is low in that same cycle.
- Counters and `m_len_block` remain readable in IDLE until the next `start`.
- `m_*_valid` drop only via handshake or reset. `m_*_data` and `m_*_keep` are stable while valid and not ready.
- Reset mid-message returns immediately to IDLE with the reset values above. No residual valid is left on any channel.

## Test plan
- AAD: 2 beats, keep FFFF. Payload: 3 beats, last keep 00FF. Core ready held high. Required:
  - 5 forwarded beats, in order;
  - `aad_bytes=32`, `pld_bytes=40`;
  - `m_len_block=128'h0000000000000028_0000000000000020`;
  - `done` exactly once;
  - `err=0`.
- Empty AAD (single keep 0000, last), then payload of 1 beat with keep FFFF. Required: no `m_aad_valid` ever; `m_len_block=128'h10_0000000000000000`.
- `m_aad_ready` toggling 1010… and `m_pld_ready` held low for 5 cycles. Required: data held stable; no beat lost or duplicated; `s_pld_ready` stays low until the AAD drain.
- Partial keep 000F on a non-last payload beat. Required: `err=1` stays sticky through `done`; the next `start` clears it.
- Reset asserted while in PLD with `m_pld_valid=1`. Required: all outputs read 0 asynchronously. After release, a fresh `start` gives correct counts.
- `start` pulsed during AAD. Required: ignored; counts are unaffected.
